// File: rtl/genius_engine.sv
// genius_engine: Simon/Genius game core with sequence store, LFSR, timers and game FSM
module genius_engine #(
  parameter int NUM_COLORS = 4,
  parameter int MAX_STEPS = 32,
  parameter int SLOW_TICKS = 25_000_000,
  parameter int FAST_TICKS = 10_000_000,
  parameter int TIMEOUT_TICKS = 150_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int CW = $clog2(NUM_COLORS),
  localparam int SW = $clog2(MAX_STEPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  speed,
  input  logic [1:0]            difficulty,
  input  logic [NUM_COLORS-1:0] player_button,
  output logic [NUM_COLORS-1:0] led,
  output logic [SW-1:0]         score,
  output logic                  busy,
  output logic                  win,
  output logic                  lose
);
  localparam int AW = MAX_STEPS > 1 ? $clog2(MAX_STEPS) : 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_TICKS - 1);
  typedef enum logic [2:0] {IDLE, ADD, ADD_CMD, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, LOSE} state_t;
  state_t state;
  logic [CW-1:0] mem [MAX_STEPS];
  logic [SW-1:0] len, idx, idx1, target;
  logic [31:0] tmr, t_on, t8;
  logic [15:0] lfsr;
  logic [NUM_COLORS-1:0] btn_q;
  logic start_q, mode_q, speed_q, press, multi, valid, mem_we;
  logic [1:0] diff_q;
  logic [CW-1:0] enc, newc, first, exp_col;

  function automatic logic [NUM_COLORS-1:0] oh(input logic [CW-1:0] c);
    return NUM_COLORS'(1) << c;
  endfunction

  // Encode the pressed colour (meaningful only when one-hot)
  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_COLORS; i++) if (player_button[i]) enc = CW'(i);
  end

  // Press detection, timing and sequence helpers
  always_comb begin
    press = (|player_button) && !(|btn_q);
    multi = press && ((player_button & (player_button - NUM_COLORS'(1))) != '0);
    valid = press && !multi;
    t_on = speed_q ? 32'(FAST_TICKS) : 32'(SLOW_TICKS);
    t8 = 32'd8 << diff_q;
    target = t8 > 32'(MAX_STEPS) ? SW'(MAX_STEPS) : SW'(t8);
    idx1 = idx + SW'(1);
    exp_col = mem[idx[AW-1:0]];
    newc = state == ADD_CMD ? enc : lfsr[CW-1:0];
    first = len == '0 ? newc : mem[0];
    mem_we = (state == ADD && !mode_q) || (state == ADD_CMD && valid);
  end

  assign busy = state != IDLE;

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Previous samples for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_q <= '0;
      start_q <= 1'b0;
    end else begin
      btn_q <= player_button;
      start_q <= start;
    end

  // Sequence store, deliberately left unreset
  always_ff @(posedge clk)
    if (mem_we) mem[len[AW-1:0]] <= newc;

  // Game FSM with registered led/score/win/lose
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      led <= '0;
      score <= '0;
      win <= 1'b0;
      lose <= 1'b0;
      len <= '0;
      idx <= '0;
      tmr <= '0;
      mode_q <= 1'b0;
      speed_q <= 1'b0;
      diff_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          led <= '0;
          if (start && !start_q) begin
            score <= '0;
            len <= '0;
            idx <= '0;
            win <= 1'b0;
            lose <= 1'b0;
            mode_q <= mode;
            speed_q <= speed;
            diff_q <= difficulty;
            state <= ADD;
          end
        end
        ADD: begin
          idx <= '0;
          tmr <= '0;
          if (mode_q) begin
            led <= player_button;
            state <= ADD_CMD;
          end else begin
            len <= len + SW'(1);
            led <= oh(first);
            state <= PLAY_ON;
          end
        end
        ADD_CMD: begin
          led <= player_button;
          if (valid) begin
            len <= len + SW'(1);
            idx <= '0;
            tmr <= '0;
            led <= oh(first);
            state <= PLAY_ON;
          end else if (multi || tmr == TO_LAST) begin
            tmr <= '0;
            led <= '0;
            state <= LOSE;
          end else tmr <= tmr + 32'd1;
        end
        PLAY_ON: begin
          if (tmr == t_on - 32'd1) begin
            tmr <= '0;
            led <= '0;
            state <= PLAY_OFF;
          end else tmr <= tmr + 32'd1;
        end
        PLAY_OFF: begin
          if (tmr == t_on - 32'd1) begin
            tmr <= '0;
            if (idx1 == len) begin
              idx <= '0;
              led <= player_button;
              state <= WAIT_IN;
            end else begin
              idx <= idx1;
              led <= oh(mem[idx1[AW-1:0]]);
              state <= PLAY_ON;
            end
          end else tmr <= tmr + 32'd1;
        end
        WAIT_IN: begin
          led <= player_button;
          if (press) begin
            tmr <= '0;
            if (multi || enc != exp_col) begin
              led <= oh(exp_col);
              state <= LOSE;
            end else if (idx1 != len) idx <= idx1;
            else begin
              score <= score == SW'(MAX_STEPS) ? score : score + SW'(1);
              if (len == target) begin
                led <= '1;
                state <= WIN;
              end else state <= ADD;
            end
          end else if (tmr == TO_LAST) begin
            tmr <= '0;
            led <= oh(exp_col);
            state <= LOSE;
          end else tmr <= tmr + 32'd1;
        end
        WIN: begin
          if (tmr == (t_on << 1) - 32'd1) begin
            tmr <= '0;
            led <= '0;
            win <= 1'b1;
            state <= IDLE;
          end else tmr <= tmr + 32'd1;
        end
        LOSE: begin
          if (tmr == (t_on << 1) - 32'd1) begin
            tmr <= '0;
            led <= '0;
            lose <= 1'b1;
            state <= IDLE;
          end else tmr <= tmr + 32'd1;
        end
      endcase
    end
endmodule
